// File: rtl/piece_scheduler_if.sv
// Bundle between the piece blocks / game host and the piece scheduler.
// master drives Start and the touchdown reports; slave is the scheduler.
interface piece_scheduler_if;
  logic                   Start;
  logic [6:0]             En_New_Static;
  logic [6:0][3:0][4:0]   New_Static_Row;
  logic [6:0][3:0][3:0]   New_Static_Column;
  logic [6:0]             Active;
  logic [23:0][9:0]       Static_Array;
  logic [2:0]             Cur_Piece;
  logic [2:0]             Next_Piece;
  logic [15:0]            Lines_Cleared;
  logic                   Game_Over;

  modport master (
    output Start, En_New_Static, New_Static_Row, New_Static_Column,
    input  Active, Static_Array, Cur_Piece, Next_Piece, Lines_Cleared, Game_Over
  );

  modport slave (
    input  Start, En_New_Static, New_Static_Row, New_Static_Column,
    output Active, Static_Array, Cur_Piece, Next_Piece, Lines_Cleared, Game_Over
  );
endinterface

// File: rtl/piece_scheduler.sv
// Piece scheduler for a 24x10 falling-block playfield: picks pieces from an LFSR,
// enables the current piece block, commits its landed cells and clears full rows.
module piece_scheduler (
  input  logic             Clk,
  input  logic             Reset,
  piece_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SPAWN, WAIT, COMMIT, SCAN, SHIFT, GAMEOVER} state_t;

  state_t           state_reg, state_next;
  logic [15:0]      lfsr_reg, lfsr_next;
  logic [23:0][9:0] array_reg, array_next;
  logic [15:0]      lines_reg, lines_next;
  logic [2:0]       cur_reg, cur_next;
  logic [2:0]       next_reg, next_next;
  logic [6:0]       active_reg, active_next;
  logic [4:0]       ptr_reg, ptr_next;
  logic [3:0][4:0]  cell_row_reg, cell_row_next;
  logic [3:0][3:0]  cell_col_reg, cell_col_next;

  logic [2:0]       candidate;
  logic             spawn_blocked;
  logic [6:0]       cur_onehot;
  logic [23:0]      row_full;

  genvar gi;
  generate
    for (gi = 0; gi < 24; gi++) begin : g_row_full
      assign row_full[gi] = &array_reg[gi];
    end
    for (gi = 0; gi < 7; gi++) begin : g_onehot
      assign cur_onehot[gi] = (cur_reg == 3'(gi));
    end
  endgenerate

  assign candidate     = (lfsr_reg[2:0] == 3'd7) ? 3'd0 : lfsr_reg[2:0];
  assign lfsr_next     = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  // Spawn zone is the top two rows across the four middle columns.
  assign spawn_blocked = (|array_reg[0][6:3]) | (|array_reg[1][6:3]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      lfsr_reg     <= 16'hACE1;
      array_reg    <= '0;
      lines_reg    <= '0;
      cur_reg      <= '0;
      next_reg     <= '0;
      active_reg   <= '0;
      ptr_reg      <= 5'd23;
      cell_row_reg <= '0;
      cell_col_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      array_reg    <= array_next;
      lines_reg    <= lines_next;
      cur_reg      <= cur_next;
      next_reg     <= next_next;
      active_reg   <= active_next;
      ptr_reg      <= ptr_next;
      cell_row_reg <= cell_row_next;
      cell_col_reg <= cell_col_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    array_next    = array_reg;
    lines_next    = lines_reg;
    cur_next      = cur_reg;
    next_next     = next_reg;
    active_next   = active_reg;
    ptr_next      = ptr_reg;
    cell_row_next = cell_row_reg;
    cell_col_next = cell_col_reg;

    case (state_reg)
      IDLE, GAMEOVER: begin
        active_next = '0;
        if (bus.Start) begin
          state_next = SPAWN;
          array_next = '0;
          lines_next = '0;
          ptr_next   = '0;
          cur_next   = candidate;
          next_next  = candidate;
        end
      end
      SPAWN: begin
        if (spawn_blocked) begin
          state_next  = GAMEOVER;
          active_next = '0;
        end else begin
          state_next  = WAIT;
          active_next = cur_onehot;
        end
      end
      WAIT: begin
        if (bus.En_New_Static[cur_reg]) begin
          state_next    = COMMIT;
          active_next   = '0;
          cell_row_next = bus.New_Static_Row[cur_reg];
          cell_col_next = bus.New_Static_Column[cur_reg];
        end
      end
      COMMIT: begin
        // Off-board cells are discarded rather than wrapped.
        for (int i = 0; i < 4; i++) begin
          if (cell_row_reg[i] < 5'd24 && cell_col_reg[i] < 4'd10)
            array_next[cell_row_reg[i]][cell_col_reg[i]] = 1'b1;
        end
        ptr_next   = 5'd23;
        state_next = SCAN;
      end
      SCAN: begin
        if (row_full[ptr_reg]) begin
          state_next = SHIFT;
        end else if (ptr_reg == 5'd0) begin
          state_next = SPAWN;
          cur_next   = next_reg;
          next_next  = candidate;
        end else begin
          ptr_next = ptr_reg - 5'd1;
        end
      end
      SHIFT: begin
        // Pointer stays put so the row that drops in gets rescanned.
        for (int r = 1; r < 24; r++) begin
          if (5'(r) <= ptr_reg)
            array_next[r] = array_reg[r-1];
        end
        array_next[0] = '0;
        if (lines_reg != 16'hFFFF)
          lines_next = lines_reg + 16'd1;
        state_next = SCAN;
      end
      default: begin
        state_next  = IDLE;
        active_next = '0;
      end
    endcase
  end

  assign bus.Active        = active_reg;
  assign bus.Static_Array  = array_reg;
  assign bus.Cur_Piece     = cur_reg;
  assign bus.Next_Piece    = next_reg;
  assign bus.Lines_Cleared = lines_reg;
  assign bus.Game_Over     = (state_reg == GAMEOVER);
endmodule

// File: tb/tb_piece_scheduler.sv
// Directed-plus-random bench for piece_scheduler against a row-list playfield model
// and an edge-indexed LFSR model.
module tb_piece_scheduler;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  piece_scheduler_if bus ();

  piece_scheduler dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  logic [9:0] m_arr [24];
  int         m_lines;
  logic [2:0] m_cur, m_next;

  // Edges since the last reset edge; edge j sees the seed advanced j-1 times.
  always @(posedge Clk) begin
    if (Reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  function automatic logic [15:0] lfsr_at(int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic logic [2:0] cand_at(int edge_idx);
    logic [15:0] v;
    v = lfsr_at(edge_idx - 1);
    return (v[2:0] == 3'd7) ? 3'd0 : v[2:0];
  endfunction

  function automatic logic [239:0] packed_model();
    logic [23:0][9:0] p;
    for (int r = 0; r < 24; r++) p[r] = m_arr[r];
    return p;
  endfunction

  function automatic logic model_blocked();
    logic [9:0] r0, r1;
    r0 = m_arr[0];
    r1 = m_arr[1];
    return (|r0[6:3]) || (|r1[6:3]);
  endfunction

  task automatic check(input string tag, input logic [239:0] obs, input logic [239:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] exp_active, input logic exp_go);
    check({tag, ".array"}, 240'(bus.Static_Array), packed_model());
    check({tag, ".lines"}, 240'(bus.Lines_Cleared), 240'(m_lines));
    check({tag, ".cur"},   240'(bus.Cur_Piece), 240'(m_cur));
    check({tag, ".next"},  240'(bus.Next_Piece), 240'(m_next));
    check({tag, ".go"},    240'(bus.Game_Over), 240'(exp_go));
    check({tag, ".active"}, 240'(bus.Active), 240'(exp_active));
    $display("txn %s: cur=%0d next=%0d lines=%0d go=%0b active=%b",
             tag, bus.Cur_Piece, bus.Next_Piece, bus.Lines_Cleared, bus.Game_Over, bus.Active);
  endtask

  // Full rows vanish; survivors keep order and settle at the bottom.
  task automatic model_clear(output int cleared);
    logic [9:0] keep [$];
    cleared = 0;
    for (int r = 23; r >= 0; r--) begin
      if (m_arr[r] == 10'h3FF) cleared++;
      else keep.push_back(m_arr[r]);
    end
    for (int r = 23; r >= 0; r--)
      m_arr[r] = ((23 - r) < keep.size()) ? keep[23 - r] : 10'h000;
  endtask

  task automatic model_place(input logic [3:0][4:0] r, input logic [3:0][3:0] c);
    for (int i = 0; i < 4; i++)
      if (r[i] < 5'd24 && c[i] < 4'd10) m_arr[r[i]][c[i]] = 1'b1;
  endtask

  task automatic drive_piece(input logic [3:0][4:0] r, input logic [3:0][3:0] c, input logic [2:0] piece);
    for (int p = 0; p < 7; p++) begin
      bus.New_Static_Row[p]    = 20'($urandom);
      bus.New_Static_Column[p] = 16'($urandom);
    end
    bus.New_Static_Row[piece]    = r;
    bus.New_Static_Column[piece] = c;
    bus.En_New_Static            = 7'(1) << piece;
  endtask

  task automatic start_game(input string tag);
    int s;
    @(negedge Clk);
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    s = ecount;
    bus.Start = 1'b0;
    for (int r = 0; r < 24; r++) m_arr[r] = '0;
    m_lines = 0;
    m_cur   = cand_at(s);
    m_next  = m_cur;
    check({tag, ".spawn_active"}, 240'(bus.Active), 240'(0));
    @(posedge Clk); #1;
    check_all(tag, 7'(1) << m_cur, 1'b0);
  endtask

  task automatic do_commit(input string tag, input logic [3:0][4:0] r, input logic [3:0][3:0] c);
    int e, l, lat;
    logic go;
    @(negedge Clk);
    drive_piece(r, c, m_cur);
    @(posedge Clk); #1;
    e = ecount;
    bus.En_New_Static = '0;
    check({tag, ".commit_active"}, 240'(bus.Active), 240'(0));
    model_place(r, c);
    model_clear(l);
    m_lines = (m_lines + l > 65535) ? 65535 : m_lines + l;
    lat = 1 + 24 + 2 * l;
    for (int k = 1; k <= lat; k++) begin
      @(posedge Clk); #1;
      check({tag, ".busy_active"}, 240'(bus.Active), 240'(0));
    end
    m_cur  = m_next;
    m_next = cand_at(e + lat);
    @(posedge Clk); #1;
    go = model_blocked();
    check_all(tag, go ? 7'd0 : (7'(1) << m_cur), go);
  endtask

  logic [3:0][4:0] rr;
  logic [3:0][3:0] cc;
  logic [239:0]    snap;
  logic [2:0]      other;

  initial begin
    Reset                 = 1'b1;
    bus.Start             = 1'b0;
    bus.En_New_Static     = '0;
    bus.New_Static_Row    = '0;
    bus.New_Static_Column = '0;
    for (int r = 0; r < 24; r++) m_arr[r] = '0;
    m_lines = 0; m_cur = 0; m_next = 0;

    repeat (3) @(posedge Clk);
    #1;
    check_all("reset", 7'd0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    start_game("start");

    rr = {5'd22, 5'd22, 5'd23, 5'd23}; cc = {4'd2, 4'd1, 4'd1, 4'd0};
    do_commit("first_piece", rr, cc);

    // A non-current piece reporting touchdown must be ignored.
    snap  = packed_model();
    other = (m_cur == 3'd6) ? 3'd0 : m_cur + 3'd1;
    @(negedge Clk);
    rr = {4{5'd10}}; cc = {4{4'd5}};
    drive_piece(rr, cc, other);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      check("foreign.active", 240'(bus.Active), 240'(7'(1) << m_cur));
      check("foreign.array", 240'(bus.Static_Array), snap);
    end
    bus.En_New_Static = '0;
    $display("txn foreign: piece %0d pulsed while cur=%0d", other, m_cur);

    // Build two nearly full bottom rows with debris above, then complete both.
    rr = {5'd23, 5'd23, 5'd23, 5'd23}; cc = {4'd5, 4'd4, 4'd3, 4'd2};
    do_commit("fill_a", rr, cc);
    rr = {5'd22, 5'd23, 5'd23, 5'd23}; cc = {4'd0, 4'd8, 4'd7, 4'd6};
    do_commit("fill_b", rr, cc);
    rr = {5'd22, 5'd22, 5'd22, 5'd22}; cc = {4'd6, 4'd5, 4'd4, 4'd3};
    do_commit("fill_c", rr, cc);
    rr = {5'd22, 5'd22, 5'd22, 5'd22}; cc = {4'd8, 4'd8, 4'd8, 4'd7};
    do_commit("fill_d", rr, cc);
    rr = {5'd20, 5'd21, 5'd20, 5'd21}; cc = {4'd5, 4'd3, 4'd1, 4'd0};
    do_commit("debris", rr, cc);
    rr = {5'd20, 5'd21, 5'd22, 5'd23}; cc = {4'd9, 4'd9, 4'd9, 4'd9};
    do_commit("double_clear", rr, cc);
    check("double_clear.count", 240'(bus.Lines_Cleared), 240'(2));

    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) begin
        rr[i] = 5'($urandom_range(18, 25));
        cc[i] = 4'($urandom_range(0, 11));
      end
      do_commit($sformatf("random%0d", n), rr, cc);
    end

    rr = {4{5'd1}}; cc = {4{4'd4}};
    do_commit("block_spawn", rr, cc);
    snap = packed_model();
    repeat (3) begin
      @(posedge Clk); #1;
      check("gameover.hold_array", 240'(bus.Static_Array), snap);
      check("gameover.hold_go", 240'(bus.Game_Over), 240'(1));
      check("gameover.active", 240'(bus.Active), 240'(0));
    end
    start_game("restart");

    rr = {5'd23, 5'd23, 5'd23, 5'd23}; cc = {4'd3, 4'd2, 4'd1, 4'd0};
    do_commit("row_a", rr, cc);
    rr = {5'd23, 5'd23, 5'd23, 5'd23}; cc = {4'd7, 4'd6, 4'd5, 4'd4};
    do_commit("row_b", rr, cc);
    // Completing the row, then resetting while the shift is in progress.
    @(negedge Clk);
    rr = {5'd23, 5'd23, 5'd23, 5'd23}; cc = {4'd9, 4'd9, 4'd9, 4'd8};
    drive_piece(rr, cc, m_cur);
    @(posedge Clk); #1;
    bus.En_New_Static = '0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("pre_reset.active", 240'(bus.Active), 240'(0));
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    for (int r = 0; r < 24; r++) m_arr[r] = '0;
    m_lines = 0; m_cur = 0; m_next = 0;
    check_all("reset_in_shift", 7'd0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    start_game("after_reset");
    rr = {5'd22, 5'd31, 5'd5, 5'd31}; cc = {4'd3, 4'd15, 4'd15, 4'd0};
    do_commit("offboard", rr, cc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
